// File: rtl/sramlike_mem_responder_if.sv
// sramlike_mem_responder_if: sram-like bus between an initiator and a memory responder.
// Ports (all signals, no clock):
//   req/wr/size/addr/wdata : request from the initiator
//   addr_ok                : address handshake accepted when req is also high
//   data_ok/rdata          : in-order completion pulse and read word
// Modports: master (initiator side), slave (responder side).
interface sramlike_mem_responder_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        addr_ok;
   logic        data_ok;
   modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
   modport slave (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sramlike_mem_responder.sv
// sramlike_mem_responder: fixed-latency, in-order sram-like responder backed by a byte-lane RAM.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (drops all in-flight transactions, RAM kept)
//   hold  : backpressure, forces addr_ok low
//   bus   : sram-like slave side (req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out)
module sramlike_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int LATENCY     = 2,
   parameter int OUTSTANDING = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   input logic                     hold,
   sramlike_mem_responder_if.slave bus
);
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [31:0]           q_data [OUTSTANDING];
   logic                  q_wr [OUTSTANDING];
   logic [DW-1:0]         q_cd [OUTSTANDING];
   logic [PW-1:0]         head, tail;
   logic [CW-1:0]         count;
   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            lo;
   logic [3:0]            be;
   logic                  pop, push;
   logic                  unused;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign idx    = bus.addr[ADDR_WIDTH+1:2];
   assign lo     = bus.addr[1:0];
   assign unused = ^bus.addr[31:ADDR_WIDTH+2];

   // all entries share LATENCY, so only the head can ever be the one reaching zero first
   assign pop  = (count != '0) && (q_cd[head] == '0);
   assign push = bus.req && bus.addr_ok;

   // a full queue still accepts when its head retires in the same cycle
   assign bus.addr_ok = !hold && ((count < CW'(OUTSTANDING)) || pop);
   assign bus.data_ok = pop;
   assign bus.rdata   = (pop && !q_wr[head]) ? q_data[head] : '0;

   // misaligned halfword/word accesses get no lanes but still complete normally
   assign be = (bus.size == 2'd0) ? 4'b0001 << lo :
               (bus.size == 2'd1) ? (lo[0] ? 4'b0000 : lo[1] ? 4'b1100 : 4'b0011) :
               ((lo != 2'd0) ? 4'b0000 : 4'b1111);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop) head <= nxt(head);
         if (push) tail <= nxt(tail);
         if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      end

   // payload needs no reset: an entry is only meaningful while count covers it
   always_ff @(posedge clk) begin
      for (int i = 0; i < OUTSTANDING; i++)
         if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - 1'b1;
      if (push) begin
         q_cd[tail]   <= DW'(LATENCY - 1);
         q_wr[tail]   <= bus.wr;
         q_data[tail] <= mem[idx];
      end
   end

   always_ff @(posedge clk)
      for (int l = 0; l < 4; l++)
         if (push && bus.wr && be[l]) mem[idx][8*l +: 8] <= bus.wdata[8*l +: 8];
endmodule

// File: tb/tb_sramlike_mem_responder.sv
// tb_sramlike_mem_responder: random and directed checks of the sram-like responder against a due-time reference model.
module tb_sramlike_mem_responder;
   localparam int LAT = 2, OUTS = 2;

   logic clk = 0, rst_n = 1, hold_a = 0, hold_b = 0;
   always #5 clk = ~clk;

   sramlike_mem_responder_if ia();
   sramlike_mem_responder_if ib();

   sramlike_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT), .OUTSTANDING(OUTS)) u_a (
      .clk(clk), .rst_n(rst_n), .hold(hold_a), .bus(ia));
   sramlike_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3), .OUTSTANDING(2)) u_b (
      .clk(clk), .rst_n(rst_n), .hold(hold_b), .bus(ib));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, act, exp);
   endtask

   // reference model: each accepted transaction is due exactly LAT cycles later
   typedef struct {int due; logic wr; logic [31:0] data;} txn_t;
   txn_t        pend[$];
   logic [31:0] mm [1024];
   int          cyc = 0;
   logic        m_acc = 0;
   logic [31:0] last_rdata = 0;
   int          dok_cnt = 0;

   function automatic logic exp_pop();
      return pend.size() > 0 && pend[0].due == cyc;
   endfunction

   always @(negedge clk) begin
      logic p, aok;
      p   = rst_n && exp_pop();
      aok = !hold_a && (!rst_n || pend.size() < OUTS || p);
      chk("addr_ok", 32'(ia.addr_ok), 32'(aok));
      chk("data_ok", 32'(ia.data_ok), 32'(p));
      chk("rdata", ia.rdata, (p && !pend[0].wr) ? pend[0].data : 32'h0);
      if (ia.data_ok) begin
         dok_cnt++;
         last_rdata = ia.rdata;
      end
   end

   always @(posedge clk) begin
      logic p, acc;
      int nb, lo;
      logic [9:0] ix;
      txn_t t;
      if (!rst_n) begin
         pend.delete();
         m_acc = 0;
      end else begin
         p   = exp_pop();
         acc = ia.req && !hold_a && (pend.size() < OUTS || p);
         if (p) void'(pend.pop_front());
         m_acc = acc;
         if (acc) begin
            ix = ia.addr[11:2];
            t.due = cyc + LAT;
            t.wr = ia.wr;
            t.data = ia.wr ? 32'h0 : mm[ix];
            pend.push_back(t);
            nb = (ia.size == 2'd0) ? 1 : (ia.size == 2'd1) ? 2 : 4;
            lo = int'(ia.addr[1:0]);
            if (ia.wr && lo % nb == 0)
               for (int l = 0; l < 4; l++)
                  if (l >= lo && l < lo + nb) mm[ix][8*l +: 8] = ia.wdata[8*l +: 8];
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input string tag);
      for (int n = 0; n < 50; n++) begin
         step();
         if (m_acc) begin
            ia.req = 0;
            return;
         end
      end
      chk(tag, 32'(m_acc), 32'd1);
      ia.req = 0;
   endtask

   task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      ia.req = 1; ia.wr = w; ia.size = s; ia.addr = a; ia.wdata = d;
      wait_acc("accept_timeout");
   endtask

   logic       hs;
   logic [9:0] aok_v, dok_v;
   int         hsb;

   initial begin
      ia.req = 0; ia.wr = 0; ia.size = 0; ia.addr = 0; ia.wdata = 0;
      ib.req = 0; ib.wr = 0; ib.size = 0; ib.addr = 0; ib.wdata = 0;
      #2 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      step();
      issue(1, 2, 32'h100, 32'hDEADBEEF);
      issue(0, 2, 32'h100, 32'h0);
      repeat (3) step();
      chk("raw_b2b", last_rdata, 32'hDEADBEEF);
      issue(1, 2, 32'h200, 32'h0);
      issue(1, 0, 32'h201, 32'h0000AB00);
      issue(1, 1, 32'h202, 32'h12340000);
      issue(0, 0, 32'h200, 32'h0);
      repeat (3) step();
      chk("byte_lanes", last_rdata, 32'h1234AB00);
      issue(1, 2, 32'h300, 32'h0);
      issue(1, 1, 32'h301, 32'hFFFFFFFF);
      issue(1, 2, 32'h302, 32'hFFFFFFFF);
      issue(0, 2, 32'h300, 32'h0);
      repeat (3) step();
      chk("misaligned", last_rdata, 32'h0);
      issue(0, 2, 32'h100, 32'h0);
      issue(0, 2, 32'h200, 32'h0);
      dok_cnt = 0; hold_a = 1; hs = 0;
      ia.req = 1; ia.wr = 0; ia.size = 2; ia.addr = 32'h200;
      repeat (4) begin
         step();
         hs |= m_acc;
      end
      chk("hold_dok", 32'(dok_cnt), 32'd2);
      chk("hold_no_hs", 32'(hs), 32'd0);
      chk("hold_addr_ok", 32'(ia.addr_ok), 32'd0);
      hold_a = 0;
      wait_acc("hold_release");
      repeat (3) step();
      chk("hold_read", last_rdata, 32'h1234AB00);
      issue(1, 2, 32'h40, 32'hCAFE0001);
      issue(1, 2, 32'h44, 32'hCAFE0002);
      rst_n = 0; dok_cnt = 0;
      repeat (2) step();
      rst_n = 1;
      repeat (3) step();
      chk("rst_no_dok", 32'(dok_cnt), 32'd0);
      issue(0, 2, 32'h40, 32'h0);
      repeat (3) step();
      chk("rst_keep0", last_rdata, 32'hCAFE0001);
      issue(0, 2, 32'h1000_0044, 32'h0);
      repeat (3) step();
      chk("rst_keep1", last_rdata, 32'hCAFE0002);
      for (int i = 0; i < 16; i++) issue(1, 2, 32'(i * 4), $urandom);
      for (int k = 0; k < 800; k++) begin
         if (!ia.req || m_acc) begin
            ia.req = ($urandom_range(3) != 0);
            ia.wr = 1'($urandom_range(1));
            ia.size = 2'($urandom_range(3));
            ia.addr = $urandom & 32'hFFFF_F03F;
            ia.wdata = $urandom;
         end
         hold_a = ($urandom_range(7) == 0);
         step();
      end
      ia.req = 0; hold_a = 0;
      repeat (4) step();
      ib.req = 1; ib.wr = 0; ib.size = 2; ib.addr = 32'h8; hsb = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         aok_v[k] = ib.addr_ok;
         dok_v[k] = ib.data_ok;
         if (ib.req && ib.addr_ok) hsb++;
         step();
         if (hsb == 4) ib.req = 0;
      end
      chk("b_addr_ok", 32'(aok_v), 32'(10'b1111011011));
      chk("b_data_ok", 32'(dok_v), 32'(10'b0011011000));
      chk("b_handshakes", 32'(hsb), 32'd4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
